// File: rtl/exe_arbiter_pkg.sv
// Shared types and constants for the two-requester exe_unit front end.
package exe_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned OP_LAST = 32'd11;

    localparam int unsigned ADD    = 32'd0;
    localparam int unsigned OR     = 32'd1;
    localparam int unsigned NOR    = 32'd2;
    localparam int unsigned ASHR   = 32'd3;
    localparam int unsigned LSHR   = 32'd4;
    localparam int unsigned U2TOU1 = 32'd5;
    localparam int unsigned SMTOU2 = 32'd6;
    localparam int unsigned CRC3   = 32'd7;
    localparam int unsigned CRC4   = 32'd8;
    localparam int unsigned CNT0   = 32'd9;
    localparam int unsigned THERMO = 32'd10;
    localparam int unsigned ONEHOT = 32'd11;

endpackage

// File: rtl/exe_arbiter_if.sv
// Request and response handshake bundle between requesters/consumer and exe_arbiter.
interface exe_arbiter_if #(
    parameter int M = 9,
    parameter int N = 4
);
    logic [1:0]   i_req_valid;
    logic [1:0]   o_req_ready;
    logic [M-1:0] i_argA0;
    logic [M-1:0] i_argB0;
    logic [N-1:0] i_oper0;
    logic [M-1:0] i_argA1;
    logic [M-1:0] i_argB1;
    logic [N-1:0] i_oper1;
    logic         o_rsp_valid;
    logic         i_rsp_ready;
    logic         o_rsp_id;
    logic [M-1:0] o_result;
    logic         o_vf;
    logic         o_pf;
    logic         o_nf;
    logic         o_of;
    logic         o_err;

    modport master (
        output i_req_valid, i_argA0, i_argB0, i_oper0, i_argA1, i_argB1, i_oper1, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_id, o_result, o_vf, o_pf, o_nf, o_of, o_err
    );

    modport slave (
        input  i_req_valid, i_argA0, i_argB0, i_oper0, i_argA1, i_argB1, i_oper1, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_id, o_result, o_vf, o_pf, o_nf, o_of, o_err
    );
endinterface

// File: rtl/exe_arbiter_rr_arbiter2.sv
// Two-input round-robin grant; prio points at the requester that wins a tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       accept,
    output logic [1:0] grant
);

    logic prio_r;

    // One-hot grant, forced to zero when the owner is not ready to accept.
    always_comb begin
        grant = 2'b00;
        if (!enable) begin
            grant = 2'b00;
        end else begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio_r ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // Hand priority to the loser of each accepted grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      prio_r <= 1'b0;
        else if (accept) prio_r <= grant[0];
        else             prio_r <= prio_r;
    end

endmodule

// File: rtl/exe_unit.sv
// Combinational ALU: twelve opcodes, result plus overflow/parity/negative/all-ones flags.
module exe_unit
    import exe_arbiter_pkg::*;
#(
    parameter int M = 9,
    parameter int N = 4
) (
    input  logic [M-1:0] i_argA,
    input  logic [M-1:0] i_argB,
    input  logic [N-1:0] i_oper,
    output logic [M-1:0] o_result,
    output logic         o_vf,
    output logic         o_pf,
    output logic         o_nf,
    output logic         o_of
);

    // MSB-first LFSR with zero seed: remainder of d(x)*x^3 mod x^3+x+1.
    function automatic logic [2:0] crc3_f(input logic [M-1:0] d);
        logic [2:0] c;
        logic       fb;
        c = 3'b000;
        for (int i = M - 1; i >= 0; i--) begin
            fb = c[2] ^ d[i];
            c  = {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
        end
        return c;
    endfunction

    // Same scheme with x^4+x+1.
    function automatic logic [3:0] crc4_f(input logic [M-1:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = M - 1; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    function automatic logic [M-1:0] cnt0_f(input logic [M-1:0] d);
        logic [M-1:0] n;
        n = {M{1'b0}};
        for (int i = 0; i < M; i++) begin
            if (!d[i]) n = n + {{(M-1){1'b0}}, 1'b1};
            else       n = n;
        end
        return n;
    endfunction

    function automatic logic [M-1:0] thermo_f(input logic [M-1:0] d);
        logic [M-1:0] t;
        for (int i = 0; i < M; i++) t[i] = (M'(i) < d);
        return t;
    endfunction

    function automatic logic [M-1:0] onehot_f(input logic [M-1:0] d);
        logic [M-1:0] t;
        for (int i = 0; i < M; i++) t[i] = (d == M'(i));
        return t;
    endfunction

    logic [M-1:0] result_s;
    logic         vf_s;

    // Opcode decode; unsupported opcodes yield zero.
    always_comb begin
        result_s = {M{1'b0}};
        vf_s     = 1'b0;
        case (i_oper)
            N'(ADD): begin
                result_s = i_argA + i_argB;
                vf_s     = (i_argA[M-1] == i_argB[M-1]) && (result_s[M-1] != i_argA[M-1]);
            end
            N'(OR):     result_s = i_argA | i_argB;
            N'(NOR):    result_s = ~(i_argA | i_argB);
            N'(ASHR):   result_s = $signed(i_argA) >>> i_argB;
            N'(LSHR):   result_s = i_argA >> i_argB;
            N'(U2TOU1): result_s = i_argA[M-1] ? (i_argA - {{(M-1){1'b0}}, 1'b1}) : i_argA;
            N'(SMTOU2): result_s = i_argA[M-1] ? ({M{1'b0}} - {1'b0, i_argA[M-2:0]}) : i_argA;
            N'(CRC3):   result_s = {{(M-3){1'b0}}, crc3_f(i_argA)};
            N'(CRC4):   result_s = {{(M-4){1'b0}}, crc4_f(i_argA)};
            N'(CNT0):   result_s = cnt0_f(i_argA);
            N'(THERMO): result_s = thermo_f(i_argA);
            N'(ONEHOT): result_s = onehot_f(i_argA);
            default:    result_s = {M{1'b0}};
        endcase
    end

    assign o_result = result_s;
    assign o_vf     = vf_s;
    assign o_pf     = ^result_s;
    assign o_nf     = result_s[M-1];
    assign o_of     = &result_s;

endmodule

// File: rtl/exe_arbiter.sv
// Round-robin front end for exe_unit: latch winner, execute one cycle, hold response until consumed.
module exe_arbiter
    import exe_arbiter_pkg::*;
#(
    parameter int M = 9,
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    exe_arbiter_if.slave bus
);

    state_t       state_r;
    logic [M-1:0] arg_a_r, arg_b_r;
    logic [N-1:0] oper_r;
    logic         id_r;
    logic         rsp_valid_r, rsp_id_r, err_r;
    logic [M-1:0] result_r;
    logic         vf_r, pf_r, nf_r, of_r;

    logic [1:0]   grant_s;
    logic         idle_s;
    logic [M-1:0] eu_result_s;
    logic         eu_vf_s, eu_pf_s, eu_nf_s, eu_of_s;
    logic         eu_err_s;

    assign idle_s   = (state_r == IDLE) && i_rst_n;
    assign eu_err_s = (oper_r > N'(OP_LAST));

    rr_arbiter2 u_rr (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .req    (bus.i_req_valid),
        .enable (idle_s),
        .accept (|grant_s),
        .grant  (grant_s)
    );

    exe_unit #(.M(M), .N(N)) u_exe (
        .i_argA   (arg_a_r),
        .i_argB   (arg_b_r),
        .i_oper   (oper_r),
        .o_result (eu_result_s),
        .o_vf     (eu_vf_s),
        .o_pf     (eu_pf_s),
        .o_nf     (eu_nf_s),
        .o_of     (eu_of_s)
    );

    // Control FSM with operand latches and registered response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= IDLE;
            arg_a_r     <= {M{1'b0}};
            arg_b_r     <= {M{1'b0}};
            oper_r      <= {N{1'b0}};
            id_r        <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            result_r    <= {M{1'b0}};
            vf_r        <= 1'b0;
            pf_r        <= 1'b0;
            nf_r        <= 1'b0;
            of_r        <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s[1]) begin
                        arg_a_r <= bus.i_argA1;
                        arg_b_r <= bus.i_argB1;
                        oper_r  <= bus.i_oper1;
                        id_r    <= 1'b1;
                        state_r <= EXEC;
                    end else if (grant_s[0]) begin
                        arg_a_r <= bus.i_argA0;
                        arg_b_r <= bus.i_argB0;
                        oper_r  <= bus.i_oper0;
                        id_r    <= 1'b0;
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    result_r    <= eu_err_s ? {M{1'b0}} : eu_result_s;
                    vf_r        <= eu_vf_s;
                    pf_r        <= eu_pf_s;
                    nf_r        <= eu_nf_s;
                    of_r        <= eu_of_s;
                    err_r       <= eu_err_s;
                    rsp_id_r    <= id_r;
                    rsp_valid_r <= 1'b1;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (bus.i_rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_req_ready = grant_s;
    assign bus.o_rsp_valid = rsp_valid_r;
    assign bus.o_rsp_id    = rsp_id_r;
    assign bus.o_result    = result_r;
    assign bus.o_vf        = vf_r;
    assign bus.o_pf        = pf_r;
    assign bus.o_nf        = nf_r;
    assign bus.o_of        = of_r;
    assign bus.o_err       = err_r;

endmodule

// File: tb/tb_exe_arbiter.sv
// Randomized and directed bench for exe_arbiter against a transaction-level reference model.
module tb_exe_arbiter;
    import exe_arbiter_pkg::*;

    localparam int M = 9;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exe_arbiter_if #(.M(M), .N(N)) bus ();

    exe_arbiter #(.M(M), .N(N)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int result;
        bit vf, pf, nf, of, err, id;
    } rsp_t;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    bit   m_busy = 1'b0;
    int   m_age  = 0;
    bit   m_prio = 1'b0;
    rsp_t m_exp;

    int cmd_a[2], cmd_b[2], cmd_op[2];
    bit cmd_v[2];
    logic [1:0] act_ready;
    int exp_grant;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    function automatic int sgn(input int v);
        return (v >= 256) ? v - 512 : v;
    endfunction

    function automatic int polymod(input int v_in, input int p, input int k);
        int v;
        v = v_in;
        for (int bt = M - 1 + k; bt >= k; bt--)
            if (v[bt]) v = v ^ (p << (bt - k));
        return v & ((1 << k) - 1);
    endfunction

    function automatic rsp_t ref_model(input int a, input int b, input int op);
        rsp_t r;
        int   s;
        r.result = 0; r.vf = 0; r.err = 0; r.id = 0;
        case (op)
            0: begin
                r.result = (a + b) & 511;
                s = sgn(a) + sgn(b);
                r.vf = (s > 255) || (s < -256);
            end
            1:  r.result = a | b;
            2:  r.result = (~(a | b)) & 511;
            3:  r.result = (b >= 9) ? ((a >= 256) ? 511 : 0) : ((sgn(a) >>> b) & 511);
            4:  r.result = (b >= 9) ? 0 : (a >> b);
            5:  r.result = (a >= 256) ? a - 1 : a;
            6:  r.result = (a >= 256) ? ((512 - (a - 256)) & 511) : a;
            7:  r.result = polymod(a << 3, 'hB, 3);
            8:  r.result = polymod(a << 4, 'h13, 4);
            9:  r.result = 9 - $countones(a);
            10: r.result = (a >= 9) ? 511 : ((1 << a) - 1);
            11: r.result = (a < 9) ? (1 << a) : 0;
            default: begin r.result = 0; r.err = 1; end
        endcase
        r.pf = $countones(r.result) % 2;
        r.nf = (r.result >= 256);
        r.of = (r.result == 511);
        return r;
    endfunction

    task automatic new_cmd(input int r);
        cmd_op[r] = $urandom_range(0, 15);
        cmd_a[r]  = ($urandom % 2 == 0) ? $urandom_range(0, 12) : $urandom_range(0, 511);
        cmd_b[r]  = ($urandom % 2 == 0) ? $urandom_range(0, 12) : $urandom_range(0, 511);
    endtask

    // One clock: drive, check between edges, then advance the model across the next rising edge.
    task automatic step(input bit v0, input bit v1, input bit rdy);
        bit exp_valid;
        bit g;
        @(negedge clk);
        bus.i_req_valid = {v1, v0};
        bus.i_argA0 = M'(cmd_a[0]); bus.i_argB0 = M'(cmd_b[0]); bus.i_oper0 = N'(cmd_op[0]);
        bus.i_argA1 = M'(cmd_a[1]); bus.i_argB1 = M'(cmd_b[1]); bus.i_oper1 = N'(cmd_op[1]);
        bus.i_rsp_ready = rdy;
        #1;
        exp_grant = 0;
        if (!m_busy) begin
            if (v0 && v1)  exp_grant = m_prio ? 2 : 1;
            else if (v0)   exp_grant = 1;
            else if (v1)   exp_grant = 2;
        end
        act_ready = bus.o_req_ready;
        check("req_ready", act_ready, exp_grant);
        exp_valid = m_busy && (m_age >= 1);
        check("rsp_valid", bus.o_rsp_valid, exp_valid);
        if (exp_valid) begin
            check("result", bus.o_result, m_exp.result);
            check("rsp_id", bus.o_rsp_id, m_exp.id);
            check("vf", bus.o_vf, m_exp.vf);
            check("pf", bus.o_pf, m_exp.pf);
            check("nf", bus.o_nf, m_exp.nf);
            check("of", bus.o_of, m_exp.of);
            check("err", bus.o_err, m_exp.err);
        end
        if (exp_grant != 0) begin
            g = (exp_grant == 2);
            m_exp    = ref_model(cmd_a[g], cmd_b[g], cmd_op[g]);
            m_exp.id = g;
            m_busy   = 1'b1;
            m_age    = 0;
            m_prio   = !g;
        end else if (exp_valid && rdy) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_age++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.i_req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        check("rst_req_ready", bus.o_req_ready, 2'b00);
        check("rst_rsp_valid", bus.o_rsp_valid, 1'b0);
        check("rst_rsp_id", bus.o_rsp_id, 1'b0);
        check("rst_result", bus.o_result, 9'd0);
        check("rst_flags", {bus.o_vf, bus.o_pf, bus.o_nf, bus.o_of, bus.o_err}, 5'b00000);
        m_busy = 1'b0;
        m_prio = 1'b0;
        @(negedge clk);
        bus.i_req_valid = 2'b00;
        rst_n = 1'b1;
    endtask

    int alt_log[$];

    initial begin
        bus.i_req_valid = 2'b00; bus.i_rsp_ready = 1'b0;
        bus.i_argA0 = '0; bus.i_argB0 = '0; bus.i_oper0 = '0;
        bus.i_argA1 = '0; bus.i_argB1 = '0; bus.i_oper1 = '0;
        for (int r = 0; r < 2; r++) begin cmd_v[r] = 0; new_cmd(r); end
        apply_reset();

        // ADD 5+3 from requester 0
        cmd_a[0] = 5; cmd_b[0] = 3; cmd_op[0] = 0;
        step(1, 0, 1);
        check("t1_grant", act_ready, 2'b01);
        step(0, 0, 1);
        step(0, 0, 1);
        check("t1_result", bus.o_result, 9'd8);
        check("t1_id_vf_err", {bus.o_rsp_id, bus.o_vf, bus.o_err}, 3'b000);
        step(0, 0, 1);

        // simultaneous requests after reset
        apply_reset();
        cmd_a[0] = 'h1F0; cmd_b[0] = 'h00F; cmd_op[0] = 1;
        cmd_a[1] = 1;     cmd_b[1] = 1;     cmd_op[1] = 0;
        step(1, 1, 1);
        check("t2_first_grant", act_ready, 2'b01);
        step(0, 1, 1);
        step(0, 1, 1);
        check("t2_first", {bus.o_rsp_id, bus.o_of, bus.o_result}, {1'b0, 1'b1, 9'h1FF});
        step(0, 1, 1);
        check("t2_second_grant", act_ready, 2'b10);
        step(0, 0, 1);
        step(0, 0, 1);
        check("t2_second", {bus.o_rsp_id, bus.o_result}, {1'b1, 9'd2});
        step(0, 0, 1);

        // strict alternation with both held valid
        apply_reset();
        for (int c = 0; c < 60 && alt_log.size() < 6; c++) begin
            step(1, 1, 1);
            if (act_ready != 2'b00) begin
                alt_log.push_back(act_ready == 2'b10);
                new_cmd(act_ready == 2'b10);
            end
        end
        for (int i = 0; i < 6; i++)
            check("alt_order", (i < alt_log.size()) ? alt_log[i] : 9, i % 2);
        repeat (3) step(0, 0, 1);

        // consumer stalls for 5 cycles in RESP
        new_cmd(0);
        step(1, 0, 1);
        step(0, 0, 0);
        repeat (5) step(1, 1, 0);
        step(0, 0, 1);
        step(1, 1, 1);
        check("t4_regrant", act_ready != 2'b00, 1'b1);
        repeat (3) step(0, 0, 1);

        // unsupported opcode on requester 1
        cmd_a[1] = $urandom_range(0, 511); cmd_b[1] = $urandom_range(0, 511); cmd_op[1] = 13;
        step(0, 1, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        check("t5_err", {bus.o_rsp_id, bus.o_err, bus.o_vf, bus.o_result}, {1'b1, 1'b1, 1'b0, 9'd0});
        step(0, 0, 1);

        // reset while executing
        new_cmd(0);
        step(1, 0, 1);
        apply_reset();
        step(1, 1, 1);
        check("t6_grant_after_rst", act_ready, 2'b01);
        repeat (3) step(0, 0, 1);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (cmd_v[r] && ($urandom % 16 == 0)) cmd_v[r] = 0;
                else if (!cmd_v[r] && ($urandom % 2 == 0)) begin
                    cmd_v[r] = 1;
                    new_cmd(r);
                end
            end
            step(cmd_v[0], cmd_v[1], ($urandom % 4) != 0);
            if (act_ready[0]) cmd_v[0] = 0;
            if (act_ready[1]) cmd_v[1] = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/exe_arbiter.md
# exe_arbiter

Two-requester front end for the `exe_unit` ALU, which it instantiates. Requesters issue commands over a valid/ready handshake. The block arbitrates round-robin and latches the winner's operands and opcode. It then drives `exe_unit` from those registers and returns the registered result, flags and requester ID over a second valid/ready handshake. It is the only path into `exe_unit` for the surrounding datapath.

## Interface
Parameters:
- `M`, 9: operand/result width, passed to `exe_unit`; must be ≥ 9.
- `N`, 4: opcode width, passed to `exe_unit`.

Ports:
- `i_clk`  in  1  clock; all state changes on its rising edge.
- `i_rst_n`  in  1  reset; asynchronous assert, active-low.
- `i_req_valid`  in  2  bit r set: requester r presents a command.
- `o_req_ready`  out  2  bit r set: requester r's command is accepted this cycle.
- `i_argA0`, `i_argB0`  in  M  operands, requester 0.
- `i_oper0`  in  N  opcode, requester 0.
- `i_argA1`, `i_argB1`  in  M  operands, requester 1.
- `i_oper1`  in  N  opcode, requester 1.
- `o_rsp_valid`  out  1  response registers hold a valid result.
- `i_rsp_ready`  in  1  consumer accepts the response.
- `o_rsp_id`  out  1  requester that issued the command.
- `o_result`  out  M  registered `exe_unit` result.
- `o_vf`, `o_pf`, `o_nf`, `o_of`  out  1 each  registered `exe_unit` flags.
- `o_err`  out  1  opcode > 11 (unsupported); `o_result` is 0 in this case.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - `o_req_ready` is driven combinationally and is one-hot or zero.
  - If exactly one request is valid, that requester is granted.
  - If both are valid, the requester pointed to by the priority pointer `prio` is granted.
  - On grant:
    - latch argA, argB, oper and id;
    - set `prio` to the non-granted requester;
    - go to EXEC.
  - With no valid request: stay in IDLE; `prio` is unchanged.
- **EXEC:** `exe_unit` evaluates the latched operands combinationally. At the clock edge:
  - `o_result` and `o_vf`, `o_pf`, `o_nf`, `o_of` load from `exe_unit`;
  - `o_err` loads (latched oper > 11); `o_rsp_id` loads;
  - state goes to RESP.
- **RESP:**
  - `o_rsp_valid` = 1.
  - All response outputs are held stable until `i_rsp_ready` = 1, then go to IDLE.
  - `o_req_ready` = 0 throughout EXEC and RESP.
- A requester must hold its command stable while valid and not ready. Dropping valid before ready is legal; that request is simply not taken.
- Width rules: no extension or truncation in the block; all operand widths are M, and `exe_unit` owns result width semantics.

## Timing
- Reset (async, `i_rst_n` = 0):
  - state = IDLE, `prio` = 0;
  - `o_rsp_valid`, `o_rsp_id`, `o_result`, `o_vf`, `o_pf`, `o_nf`, `o_of`, `o_err` all 0;
  - `o_req_ready` = 0 while in reset.
- Latency: request accepted at edge T; `o_rsp_valid` rises after edge T+1; earliest consume at edge T+2.
- Throughput: one command per 3 cycles with `i_rsp_ready` tied high.
- No new grant in the cycle a response is consumed; IDLE follows.
- Reset mid-EXEC or mid-RESP: the in-flight command is discarded with no response, and all outputs return to reset values immediately.
- Simultaneous requests on consecutive commands alternate strictly: 0, 1, 0, 1.

## Structure
- Package `exe_arbiter_pkg` contains:
  - state enum (IDLE, EXEC, RESP);
  - `OP_LAST` = 11 constant;
  - opcode localparams: ADD = 0, OR = 1, NOR = 2, ASHR = 3, LSHR = 4, U2TOU1 = 5, SMTOU2 = 6, CRC3 = 7, CRC4 = 8, CNT0 = 9, THERMO = 10, ONEHOT = 11.
- Sub-module `rr_arbiter2`: two-input round-robin grant with a `prio` register and an update-on-accept input.
- `exe_unit` is instantiated once with `M` and `N` passed through.

## Test plan
- Req0 ADD, A = 9'd5, B = 9'd3, rsp_ready = 1 → response at T+2 with result 9'd8, id 0, vf 0, err 0.
- After reset, both valid: req0 OR (A = 9'h1F0, B = 9'h00F); req1 ADD (1, 1) → first response id 0, result 9'h1FF, of 1; second response id 1, result 9'd2.
- Both requesters held valid for 6 commands → grant order 0, 1, 0, 1, 0, 1; each `o_req_ready` pulse lasts one cycle.
- Hold `i_rsp_ready` = 0 for 5 cycles in RESP → result, flags, id unchanged; `o_req_ready` stays 0; release → IDLE next cycle.
- Req1 with oper = 4'd13 → result 0, err 1, vf 0, id 1.
- Assert `i_rst_n` = 0 during EXEC → all outputs 0 at once with no response; after release, simultaneous requests grant requester 0 first.
